inst_mem_ctrl: RTL and testbench

//  Sequences and shares the single-port instruction memory between two requesters:
//  - the program loader (boot-time writes);
//  - the CPU fetch stage (reads).

---
 rtl/inst_mem_pkg.sv | 8 +
 rtl/im_arb_prio.sv | 34 +++
 rtl/inst_mem_ctrl.sv | 74 +++++++
 tb/tb_inst_mem_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared state type and constants for the instruction-memory controller
package inst_mem_pkg;
    typedef enum logic {LOAD, RUN} state_t;
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int WORD_SHIFT     = 2;
endpackage

// File: rtl/im_arb_prio.sv
// im_arb_prio: loader-first arbiter that forces a fetch grant after STARVE_MAX loader wins
// ports: clk, rst_n (async, active-low); l_req/f_req requests; en_fetch allows fetch
//        service (RUN only); l_gnt/f_gnt same-cycle one-hot grants
module im_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic l_req,
    input  logic f_req,
    input  logic en_fetch,
    output logic l_gnt,
    output logic f_gnt
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;
    logic          f_ok;
    logic          starved;
    always_comb begin
        f_ok    = en_fetch & f_req;
        starved = starve_cnt == CW'(STARVE_MAX);
        f_gnt   = f_ok & (!l_req | starved);
        l_gnt   = l_req & !f_gnt;
    end
    // counts loader wins over a pending fetch; any fetch grant or idle fetch clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!f_ok || f_gnt)
            starve_cnt <= '0;
        else if (l_gnt && !starved)
            starve_cnt <= starve_cnt + CW'(1);
    end
endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: shares a single-port instruction memory between the boot loader and CPU fetch
// ports: clk, rst_n (async, active-low)
//        loader: l_req, l_addr, l_wdata, l_done -> l_gnt
//        fetch:  f_req, f_addr -> f_gnt, f_rvalid, f_rdata, f_err (misaligned PC)
//        memory: mem_cs, mem_we, mem_addr (word index), mem_wdata <- mem_rdata (1-cycle latency)
//        running: controller has left the boot-load phase
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_done,
    output logic              l_gnt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              running
);
    state_t state;
    state_t state_nxt;
    logic   rv;
    logic   er;
    logic   f_aligned;
    logic   f_rd;
    // loader request is masked during reset so no write escapes while rst_n is low
    im_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .l_req    (l_req & rst_n),
        .f_req    (f_req),
        .en_fetch (running),
        .l_gnt    (l_gnt),
        .f_gnt    (f_gnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            rv    <= 1'b0;
            er    <= 1'b0;
        end else begin
            state <= state_nxt;
            rv    <= f_gnt;
            er    <= f_gnt & !f_aligned;
        end
    end
    always_comb begin
        state_nxt = (state == LOAD && l_done) ? RUN : state;
        running   = state == RUN;
        f_aligned = f_addr[WORD_SHIFT-1:0] == '0;
        f_rd      = f_gnt & f_aligned;
        mem_cs    = l_gnt | f_rd;
        mem_we    = l_gnt;
        mem_addr  = l_gnt ? l_addr[ADDR_W-1:WORD_SHIFT] : f_rd ? f_addr[ADDR_W-1:WORD_SHIFT] : '0;
        mem_wdata = l_gnt ? l_wdata : '0;
        f_rvalid  = rv;
        f_err     = er;
        f_rdata   = (rv && !er) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: scoreboard bench for inst_mem_ctrl with a reference memory and arbitration model
module tb_inst_mem_ctrl;
    localparam int STARVE = 4;
    logic        clk = 0, rst_n = 0, l_req = 0, l_done = 0, f_req = 0;
    logic [31:0] l_addr = 0, l_wdata = 0, f_addr = 0, mem_rdata = 0;
    logic [31:0] f_rdata, mem_wdata;
    logic        l_gnt, f_gnt, f_rvalid, f_err, mem_cs, mem_we, running;
    logic [29:0] mem_addr;
    logic [31:0] arr [16];
    logic [31:0] ref_mem [16];
    typedef struct {logic [31:0] data; logic err; int cyc;} resp_t;
    resp_t exp_q[$];
    int    cyc = 0, n_chk = 0, n_pass = 0, streak = 0;
    logic  run_m = 0;

    always #5 clk = ~clk;

    inst_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_done(l_done), .l_gnt(l_gnt), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err), .mem_cs(mem_cs),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .running(running)
    );

    // single-port synchronous array, 16 words
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs) begin
            if (mem_we) arr[mem_addr[3:0]] <= mem_wdata;
            else mem_rdata <= arr[mem_addr[3:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // response monitor: one response exactly one cycle after each predicted fetch grant
    initial forever begin
        logic  exp_v;
        resp_t r;
        @(posedge clk);
        #1;
        exp_v = exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc;
        chk("f_rvalid", f_rvalid, exp_v);
        if (exp_v) begin
            r = exp_q.pop_front();
            if (f_rvalid) begin
                chk("f_rdata", f_rdata, r.data);
                chk("f_err", f_err, r.err);
            end
        end
    end

    // drive one cycle, check the issue outputs against the model, advance the model
    task automatic step(input logic lr, input logic [31:0] la, input logic [31:0] lw,
                        input logic ld, input logic fr, input logic [31:0] fa,
                        output logic el, output logic ef);
        logic al;
        @(negedge clk);
        l_req = lr; l_addr = la; l_wdata = lw; l_done = ld; f_req = fr; f_addr = fa;
        #1;
        ef = run_m && fr && (!lr || streak == STARVE);
        el = lr && !ef;
        al = fa[1:0] == 2'b00;
        chk("l_gnt", l_gnt, el);
        chk("f_gnt", f_gnt, ef);
        chk("mem_cs", mem_cs, el || (ef && al));
        chk("mem_we", mem_we, el);
        chk("mem_addr", mem_addr, el ? la[31:2] : (ef && al) ? fa[31:2] : 30'h0);
        chk("mem_wdata", mem_wdata, el ? lw : 32'h0);
        chk("running", running, run_m);
        if (ef) exp_q.push_back('{al ? ref_mem[fa[5:2]] : 32'h0, !al, cyc});
        if (el) ref_mem[la[5:2]] = lw;
        streak = (el && run_m && fr) ? streak + 1 : 0;
        if (ld) run_m = 1;
    endtask

    initial begin
        logic        g1, g2, lr, fr;
        logic [31:0] la, lw, fa;
        l_req = 1;
        #2;
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_running", running, 0);
        chk("rst_f_gnt", f_gnt, 0);
        l_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        step(1, 32'h0, 32'hAAAA_0001, 0, 1, 32'h0, g1, g2);
        step(1, 32'h4, 32'hBBBB_0002, 0, 1, 32'h0, g1, g2);
        step(1, 32'h8, 32'hCCCC_0003, 0, 1, 32'h0, g1, g2);
        for (int i = 3; i < 16; i++)
            step(1, (i << 2) | $urandom_range(0, 3), $urandom, i == 15, 1, 32'h0, g1, g2);
        step(0, 0, 0, 0, 1, 32'h4, g1, g2);
        step(0, 0, 0, 0, 1, 32'h0, g1, g2);
        step(0, 0, 0, 0, 1, 32'h8, g1, g2);
        step(0, 0, 0, 0, 1, 32'h6, g1, g2);
        for (int i = 0; i < 10; i++)
            step(1, 32'h30, 32'h1234_0000 + i, 0, 1, 32'h0, g1, g2);
        step(1, 32'h10, 32'h0000_DEAD, 0, 0, 0, g1, g2);
        step(0, 0, 0, 0, 1, 32'h10, g1, g2);
        lr = 0; fr = 0; la = 0; lw = 0; fa = 0;
        for (int i = 0; i < 500; i++) begin
            if (!lr) begin lr = ($urandom % 3) != 0; la = $urandom_range(0, 63); lw = $urandom; end
            if (!fr) begin
                fr = ($urandom % 3) != 0;
                fa = ($urandom_range(0, 15) << 2) | (($urandom % 8 == 0) ? $urandom_range(1, 3) : 0);
            end
            step(lr, la, lw, ($urandom % 16) == 0, fr, fa, g1, g2);
            if (g1) lr = 0;
            if (g2) fr = 0;
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, g1, g2);
        @(negedge clk);
        f_req = 1; f_addr = 32'h4; l_req = 1; l_addr = 32'h8;
        #1;
        rst_n = 0;
        #1;
        chk("rst2_f_gnt", f_gnt, 0);
        chk("rst2_l_gnt", l_gnt, 0);
        chk("rst2_mem_cs", mem_cs, 0);
        chk("rst2_mem_we", mem_we, 0);
        chk("rst2_mem_addr", mem_addr, 0);
        chk("rst2_running", running, 0);
        @(posedge clk);
        #2;
        chk("rst2_f_rvalid", f_rvalid, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
